// File: rtl/usbdev_aon_resume_tx.sv
// rtl/usbdev_aon_resume_tx.sv - AON USB remote-wakeup resume K transmitter (optional timeout: USBDEV_AON_RESUME_TIMEOUT_EN)
module usbdev_aon_resume_tx #(
  parameter int unsigned IdleCycles    = 1000,
  parameter int unsigned DriveCycles   = 400,
  parameter int unsigned CntWidth      = 16,
  parameter int unsigned TimeoutCycles = 20000
) (
  input  logic clk_aon_i,
  input  logic rst_aon_ni,
  input  logic usb_dp_i,
  input  logic usb_dn_i,
  input  logic usb_dppullup_en_i,
  input  logic usb_dnpullup_en_i,
  input  logic wake_detect_active_aon_i,
  input  logic remote_wake_req_aon_i,
  output logic usb_dp_o,
  output logic usb_dn_o,
  output logic usb_oe_o,
  output logic resume_busy_aon_o,
  output logic resume_done_aon_o,
  output logic resume_abort_aon_o,
  output logic cfg_err_aon_o
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitIdle = 2'd1,
    StDriveK   = 2'd2,
    StDone     = 2'd3
  } state_e;

  localparam int unsigned LongestWindow =
      (IdleCycles > DriveCycles) ?
      ((IdleCycles > TimeoutCycles) ? IdleCycles : TimeoutCycles) :
      ((DriveCycles > TimeoutCycles) ? DriveCycles : TimeoutCycles);

  localparam logic [CntWidth-1:0] IdleLast  = CntWidth'(IdleCycles - 1);
  localparam logic [CntWidth-1:0] DriveLast = CntWidth'(DriveCycles - 1);
  localparam logic [CntWidth-1:0] CntMax    = {CntWidth{1'b1}};
  localparam logic [CntWidth-1:0] CntOne    = CntWidth'(1);

  // Reject parameter sets whose longest window cannot be counted.
  if ((64'(LongestWindow) >> CntWidth) != 64'd0) begin : g_cnt_too_narrow
    $error("CntWidth too small for the configured cycle windows");
  end

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d, cnt_inc;
  logic                abort_q, abort_d;
  logic                line_j, cfg_valid;

  // J matches the pullup orientation; exactly one pullup makes a valid config.
  assign line_j    = (usb_dp_i == usb_dppullup_en_i) && (usb_dn_i == usb_dnpullup_en_i);
  assign cfg_valid = usb_dppullup_en_i ^ usb_dnpullup_en_i;
  assign cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;

`ifdef USBDEV_AON_RESUME_TIMEOUT_EN
  localparam logic [CntWidth-1:0] TmoLast = CntWidth'(TimeoutCycles - 1);
  logic [CntWidth-1:0] tmo_q, tmo_d, tmo_inc;
  assign tmo_inc = (tmo_q == CntMax) ? tmo_q : tmo_q + CntOne;

  // Timeout counter runs from WaitIdle entry.
  always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
    if (!rst_aon_ni) tmo_q <= '0;
    else             tmo_q <= tmo_d;
  end
`endif

  // State, counter and registered abort pulse.
  always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
    if (!rst_aon_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  // Next-state logic: qualify idle, drive K for a fixed window, then hold done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = 1'b0;
`ifdef USBDEV_AON_RESUME_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (remote_wake_req_aon_i && wake_detect_active_aon_i && cfg_valid) begin
          state_d = StWaitIdle;
          cnt_d   = '0;
`ifdef USBDEV_AON_RESUME_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      StWaitIdle: begin
`ifdef USBDEV_AON_RESUME_TIMEOUT_EN
        tmo_d = tmo_inc;
`endif
        if (!remote_wake_req_aon_i || !wake_detect_active_aon_i) begin
          state_d = StIdle;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (line_j && (cnt_q == IdleLast)) begin
          state_d = StDriveK;
          cnt_d   = '0;
`ifdef USBDEV_AON_RESUME_TIMEOUT_EN
        end else if (tmo_q == TmoLast) begin
          state_d = StIdle;
          cnt_d   = '0;
          abort_d = 1'b1;
`endif
        end else if (line_j) begin
          cnt_d = cnt_inc;
        end else begin
          cnt_d = '0;
        end
      end
      StDriveK: begin
        if (!wake_detect_active_aon_i) begin
          state_d = StIdle;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (cnt_q == DriveLast) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDone: begin
        if (!remote_wake_req_aon_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // K is the inverse of J, so the pad drive follows the pullup orientation.
  assign usb_oe_o           = (state_q == StDriveK);
  assign usb_dp_o           = usb_oe_o & usb_dnpullup_en_i;
  assign usb_dn_o           = usb_oe_o & usb_dppullup_en_i;
  assign resume_busy_aon_o  = (state_q == StWaitIdle) || (state_q == StDriveK);
  assign resume_done_aon_o  = (state_q == StDone);
  assign resume_abort_aon_o = abort_q;
  assign cfg_err_aon_o      = (state_q == StIdle) && remote_wake_req_aon_i && !cfg_valid;

endmodule

// File: tb/tb_usbdev_aon_resume_tx.sv
// tb/tb_usbdev_aon_resume_tx.sv - randomized scenario bench for usbdev_aon_resume_tx
module tb_usbdev_aon_resume_tx;

  localparam int IDLE  = 1000;
  localparam int DRIVE = 400;
  localparam int TMO   = 20000;

  logic clk_aon_i = 1'b0;
  logic rst_aon_ni;
  logic usb_dp_i, usb_dn_i, usb_dppullup_en_i, usb_dnpullup_en_i;
  logic wake_detect_active_aon_i, remote_wake_req_aon_i;
  logic usb_dp_o, usb_dn_o, usb_oe_o;
  logic resume_busy_aon_o, resume_done_aon_o, resume_abort_aon_o, cfg_err_aon_o;
  logic [6:0] obs;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  usbdev_aon_resume_tx #(
    .IdleCycles(IDLE), .DriveCycles(DRIVE), .CntWidth(16), .TimeoutCycles(TMO)
  ) dut (
    .clk_aon_i                (clk_aon_i),
    .rst_aon_ni               (rst_aon_ni),
    .usb_dp_i                 (usb_dp_i),
    .usb_dn_i                 (usb_dn_i),
    .usb_dppullup_en_i        (usb_dppullup_en_i),
    .usb_dnpullup_en_i        (usb_dnpullup_en_i),
    .wake_detect_active_aon_i (wake_detect_active_aon_i),
    .remote_wake_req_aon_i    (remote_wake_req_aon_i),
    .usb_dp_o                 (usb_dp_o),
    .usb_dn_o                 (usb_dn_o),
    .usb_oe_o                 (usb_oe_o),
    .resume_busy_aon_o        (resume_busy_aon_o),
    .resume_done_aon_o        (resume_done_aon_o),
    .resume_abort_aon_o       (resume_abort_aon_o),
    .cfg_err_aon_o            (cfg_err_aon_o)
  );

  always #5 clk_aon_i = ~clk_aon_i;

  assign obs = {usb_oe_o, usb_dp_o, usb_dn_o, resume_busy_aon_o,
                resume_done_aon_o, resume_abort_aon_o, cfg_err_aon_o};

  // obs/exp bit order: oe dp_o dn_o busy done abort cfg_err
  task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (oe dp dn busy done abort cfgerr)", tag, got, exp);
    end
  endtask

  // kind 0: full resume, 1: active drop in DriveK, 2: drop in WaitIdle,
  // 3: invalid pullup config, 4: timeout (non-J line throughout)
  task automatic run_scenario(input int kind);
    logic dppu, dnpu;
    logic [1:0] v;
    int glitches[$];
    int g, q, req_drop, act_low, hi, a_t, r_t, end_t;
    bit in_wait, is_glitch;
    bit e_busy, e_oe, e_done, e_abort, e_cfg;

    dppu = 1'($urandom_range(0, 1));
    dnpu = ~dppu;
    g = 0;
    repeat ($urandom_range(0, 3)) begin
      g = g + $urandom_range(1, IDLE - 1);
      glitches.push_back(g);
    end
    q = g + IDLE;              // cycle whose J sample completes qualification
    act_low = -100;
    a_t = 0;
    r_t = 0;
    case (kind)
      0: begin req_drop = q + DRIVE + $urandom_range(1, 20); end_t = req_drop + 2; end
      1: begin
        a_t = q + 1 + $urandom_range(0, DRIVE - 1);
        act_low = a_t; req_drop = a_t + 1; end_t = a_t + 4;
      end
      2: begin
        r_t = $urandom_range(1, q);
        if ($urandom_range(0, 1) == 1) begin act_low = r_t; req_drop = r_t + 1; end
        else req_drop = r_t;
        end_t = r_t + 3;
      end
      3: begin
        dppu = 1'($urandom_range(0, 1)); dnpu = dppu;
        req_drop = $urandom_range(1, 50); end_t = req_drop + 2;
      end
      default: begin req_drop = TMO + 1; end_t = TMO + 3; end
    endcase

    for (int t = -2; t <= end_t; t++) begin
      @(posedge clk_aon_i);
      #1;
      usb_dppullup_en_i        = dppu;
      usb_dnpullup_en_i        = dnpu;
      remote_wake_req_aon_i    = (t >= 0) && (t < req_drop);
      wake_detect_active_aon_i = (t != act_low);
      is_glitch = 1'b0;
      foreach (glitches[i]) if (glitches[i] == t) is_glitch = 1'b1;
      in_wait = (kind != 3) && (t >= 1) && (t <= q);
      if (kind == 4 || (in_wait && is_glitch)) begin
        do v = 2'($urandom_range(0, 3)); while (v == {dppu, dnpu});
        {usb_dp_i, usb_dn_i} = v;
      end else if (in_wait) begin
        {usb_dp_i, usb_dn_i} = {dppu, dnpu};
      end else begin
        {usb_dp_i, usb_dn_i} = 2'($urandom_range(0, 3));
      end

      @(negedge clk_aon_i);
      e_busy = 0; e_oe = 0; e_done = 0; e_abort = 0; e_cfg = 0;
      case (kind)
        0: begin
          e_busy = (t >= 1) && (t <= q + DRIVE);
          e_oe   = (t >= q + 1) && (t <= q + DRIVE);
          e_done = (t >= q + DRIVE + 1) && (t <= req_drop);
        end
        1: begin
          e_busy  = (t >= 1) && (t <= a_t);
          e_oe    = (t >= q + 1) && (t <= a_t);
          e_abort = (t == a_t + 1);
        end
        2: begin
          e_busy  = (t >= 1) && (t <= r_t);
          e_abort = (t == r_t + 1);
        end
        3: e_cfg = (t >= 0) && (t < req_drop);
        default: begin
          hi = TMO;
          e_busy  = (t >= 1) && (t <= hi);
          e_abort = (t == hi + 1);
        end
      endcase
      check_eq($sformatf("kind%0d t=%0d", kind, t), obs,
               {e_oe, e_oe & dnpu, e_oe & dppu, e_busy, e_done, e_abort, e_cfg});
    end
  endtask

  initial begin
    rst_aon_ni = 1'b0;
    usb_dp_i = 1'b0; usb_dn_i = 1'b0;
    usb_dppullup_en_i = 1'b1; usb_dnpullup_en_i = 1'b0;
    wake_detect_active_aon_i = 1'b1; remote_wake_req_aon_i = 1'b0;
    repeat (2) begin
      @(negedge clk_aon_i);
      check_eq("reset", obs, 7'b0);
    end
    @(posedge clk_aon_i);
    #1 rst_aon_ni = 1'b1;

    for (int i = 0; i < 14; i++) run_scenario(i % 4);
`ifdef USBDEV_AON_RESUME_TIMEOUT_EN
    run_scenario(4);
`endif

    // Reset asserted in the middle of driving K.
    @(posedge clk_aon_i);
    #1;
    usb_dppullup_en_i = 1'b1; usb_dnpullup_en_i = 1'b0;
    usb_dp_i = 1'b1; usb_dn_i = 1'b0;
    wake_detect_active_aon_i = 1'b1; remote_wake_req_aon_i = 1'b1;
    repeat (IDLE + 100) @(posedge clk_aon_i);
    @(negedge clk_aon_i);
    check_eq("mid_drive", obs, 7'b1011000);
    #2 rst_aon_ni = 1'b0;
    #1 check_eq("async_reset", obs, 7'b0);
    remote_wake_req_aon_i = 1'b0;
    @(posedge clk_aon_i);
    #1 rst_aon_ni = 1'b1;
    repeat (2) begin
      @(negedge clk_aon_i);
      check_eq("post_reset", obs, 7'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
